l2_port_arbiter: RTL and testbench

Shares the single L2 refill/writeback port between the instruction cache and data cache. It latches one-cycle miss/writeback pulses from both caches and issues them to L2 one transaction at a time. It routes each L2 response back to the cache that owns it. Sits between the L1 caches and the L2 controller.

---
 rtl/l2_arb_pkg.sv | 10 +
 rtl/l2_arb_slot.sv | 56 +++++
 rtl/l2_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 port arbiter.
// Build option: define L2_ARB_RR_EN for round-robin between IC and DC reads.
package l2_arb_pkg;
    localparam int L2_LINE_ADDR_WIDTH = 25;
    localparam int L2_LINE_WIDTH      = 1024;
    localparam int L2_NUM_SLOTS       = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
    typedef enum logic [1:0] {SRC_IC, SRC_DC_RD, SRC_DC_WB} arb_src_e;
endpackage

// File: rtl/l2_arb_slot.sv
// One pending-request slot: valid flag, line address, optional line data.
// A set pulse while already pending is dropped and reported on overrun.
module l2_arb_slot
    import l2_arb_pkg::*;
#(
    parameter int AW       = L2_LINE_ADDR_WIDTH,
    parameter int DW       = L2_LINE_WIDTH,
    parameter bit HAS_DATA = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          set,
    input  logic [AW-1:0] set_addr,
    input  logic [DW-1:0] set_data,
    input  logic          clear,
    output logic          pending,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          overrun
);
    logic          pending_reg;
    logic [AW-1:0] addr_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_reg <= 1'b0;
            addr_reg    <= '0;
        end else if (set && !pending_reg) begin
            pending_reg <= 1'b1;
            addr_reg    <= set_addr;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end
    end

    generate
        if (HAS_DATA) begin : g_data
            logic [DW-1:0] data_reg;
            always_ff @(posedge CLK) begin
                if (RST)
                    data_reg <= '0;
                else if (set && !pending_reg)
                    data_reg <= set_data;
            end
            assign data = data_reg;
        end else begin : g_no_data
            logic unused_set_data;
            assign unused_set_data = ^set_data;
            assign data = '0;
        end
    endgenerate

    assign pending = pending_reg;
    assign addr    = addr_reg;
    assign overrun = set && pending_reg;
endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between I-cache refills, D-cache refills and D-cache writebacks.
// Build option: L2_ARB_RR_EN selects round-robin between the two read sources (default fixed DC>IC).
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int LINE_ADDR_WIDTH = L2_LINE_ADDR_WIDTH,
    parameter int LINE_WIDTH      = L2_LINE_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       IC_ADDR_VALID,
    input  logic [LINE_ADDR_WIDTH-1:0] IC_ADDR,
    output logic [LINE_WIDTH-1:0]      IC_DATA,
    output logic                       IC_DATA_VALID,
    input  logic                       DC_ADDR_VALID,
    input  logic [LINE_ADDR_WIDTH-1:0] DC_ADDR,
    input  logic                       DC_WB_VALID,
    input  logic [LINE_ADDR_WIDTH-1:0] DC_WADDR,
    input  logic [LINE_WIDTH-1:0]      DC_WDATA,
    output logic [LINE_WIDTH-1:0]      DC_DATA,
    output logic                       DC_DATA_VALID,
    output logic                       DC_WB_DONE,
    output logic                       L2_REQ_VALID,
    input  logic                       L2_REQ_READY,
    output logic                       L2_REQ_WRITE,
    output logic [LINE_ADDR_WIDTH-1:0] L2_REQ_ADDR,
    output logic [LINE_WIDTH-1:0]      L2_WDATA,
    input  logic                       L2_RESP_VALID,
    input  logic [LINE_WIDTH-1:0]      L2_RDATA,
    output logic                       OVERRUN
);
    localparam int AW = LINE_ADDR_WIDTH;
    localparam int DW = LINE_WIDTH;

    arb_state_e    state_reg;
    arb_src_e      grant_reg, grant_next;
    logic          req_valid_reg, req_write_reg, overrun_reg;
    logic [AW-1:0] req_addr_reg;
    logic [DW-1:0] wdata_reg, ic_data_reg, dc_data_reg;
    logic          ic_valid_reg, dc_valid_reg, wb_done_reg;

    logic [L2_NUM_SLOTS-1:0] set_v, clear_v, slot_pend, ovr_v, eff;
    logic [AW-1:0] set_addr  [L2_NUM_SLOTS];
    logic [AW-1:0] slot_addr [L2_NUM_SLOTS];
    logic [AW-1:0] eff_addr  [L2_NUM_SLOTS];
    logic [DW-1:0] set_data  [L2_NUM_SLOTS];
    logic [DW-1:0] slot_data [L2_NUM_SLOTS];
    logic [DW-1:0] eff_wdata;

    assign set_v[SRC_IC]       = IC_ADDR_VALID;
    assign set_v[SRC_DC_RD]    = DC_ADDR_VALID;
    assign set_v[SRC_DC_WB]    = DC_WB_VALID;
    assign set_addr[SRC_IC]    = IC_ADDR;
    assign set_addr[SRC_DC_RD] = DC_ADDR;
    assign set_addr[SRC_DC_WB] = DC_WADDR;

    generate
        for (genvar gi = 0; gi < L2_NUM_SLOTS; gi++) begin : g_slot
            assign set_data[gi] = (gi == int'(SRC_DC_WB)) ? DC_WDATA : '0;
            assign clear_v[gi]  = (state_reg == WAIT) && L2_RESP_VALID &&
                                  (grant_reg == arb_src_e'(2'(gi)));

            l2_arb_slot #(
                .AW       (AW),
                .DW       (DW),
                .HAS_DATA (gi == int'(SRC_DC_WB))
            ) u_slot (
                .CLK      (CLK),
                .RST      (RST),
                .set      (set_v[gi]),
                .set_addr (set_addr[gi]),
                .set_data (set_data[gi]),
                .clear    (clear_v[gi]),
                .pending  (slot_pend[gi]),
                .addr     (slot_addr[gi]),
                .data     (slot_data[gi]),
                .overrun  (ovr_v[gi])
            );

            // A pulse landing in the same IDLE cycle is granted straight from the inputs.
            assign eff[gi]      = slot_pend[gi] | set_v[gi];
            assign eff_addr[gi] = slot_pend[gi] ? slot_addr[gi] : set_addr[gi];
        end
    endgenerate

    assign eff_wdata = slot_pend[SRC_DC_WB] ? slot_data[SRC_DC_WB] : DC_WDATA;

    logic unused_rd_data;
    assign unused_rd_data = ^{slot_data[SRC_IC], slot_data[SRC_DC_RD]};

`ifdef L2_ARB_RR_EN
    // Pointer only moves on a contested grant, so an uncontested read does not steal the turn.
    logic rr_favor_ic_reg;
    logic contended;
`endif

    always_comb begin
        grant_next = SRC_IC;
`ifdef L2_ARB_RR_EN
        contended  = 1'b0;
`endif
        if (eff[SRC_DC_WB]) begin
            grant_next = SRC_DC_WB;
        end else if (eff[SRC_DC_RD] && eff[SRC_IC]) begin
`ifdef L2_ARB_RR_EN
            contended  = 1'b1;
            grant_next = rr_favor_ic_reg ? SRC_IC : SRC_DC_RD;
`else
            grant_next = SRC_DC_RD;
`endif
        end else if (eff[SRC_DC_RD]) begin
            grant_next = SRC_DC_RD;
        end
    end

`ifdef L2_ARB_RR_EN
    always_ff @(posedge CLK) begin
        if (RST)
            rr_favor_ic_reg <= 1'b0;
        else if (state_reg == IDLE && contended)
            rr_favor_ic_reg <= (grant_next == SRC_DC_RD);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            grant_reg     <= SRC_IC;
            req_valid_reg <= 1'b0;
            req_write_reg <= 1'b0;
            req_addr_reg  <= '0;
            wdata_reg     <= '0;
            ic_data_reg   <= '0;
            dc_data_reg   <= '0;
            ic_valid_reg  <= 1'b0;
            dc_valid_reg  <= 1'b0;
            wb_done_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            ic_valid_reg <= 1'b0;
            dc_valid_reg <= 1'b0;
            wb_done_reg  <= 1'b0;
            if (|ovr_v)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (|eff) begin
                        grant_reg     <= grant_next;
                        req_addr_reg  <= eff_addr[grant_next];
                        req_write_reg <= (grant_next == SRC_DC_WB);
                        if (grant_next == SRC_DC_WB)
                            wdata_reg <= eff_wdata;
                        req_valid_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (L2_REQ_READY) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (L2_RESP_VALID) begin
                        state_reg <= IDLE;
                        case (grant_reg)
                            SRC_IC: begin
                                ic_data_reg  <= L2_RDATA;
                                ic_valid_reg <= 1'b1;
                            end
                            SRC_DC_RD: begin
                                dc_data_reg  <= L2_RDATA;
                                dc_valid_reg <= 1'b1;
                            end
                            default: wb_done_reg <= 1'b1;
                        endcase
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign IC_DATA       = ic_data_reg;
    assign IC_DATA_VALID = ic_valid_reg;
    assign DC_DATA       = dc_data_reg;
    assign DC_DATA_VALID = dc_valid_reg;
    assign DC_WB_DONE    = wb_done_reg;
    assign L2_REQ_VALID  = req_valid_reg;
    assign L2_REQ_WRITE  = req_write_reg;
    assign L2_REQ_ADDR   = req_addr_reg;
    assign L2_WDATA      = wdata_reg;
    assign OVERRUN       = overrun_reg;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: cycle-level reference model plus literal checkpoints.
// Honours L2_ARB_RR_EN the same way the design does.
module tb_l2_port_arbiter;
    localparam int AW = 25;
    localparam int LW = 1024;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IC_ADDR_VALID = 1'b0, DC_ADDR_VALID = 1'b0, DC_WB_VALID = 1'b0;
    logic [AW-1:0] IC_ADDR = '0, DC_ADDR = '0, DC_WADDR = '0;
    logic [LW-1:0] DC_WDATA = '0, L2_RDATA = '0;
    logic          L2_REQ_READY = 1'b0, L2_RESP_VALID = 1'b0;
    logic [LW-1:0] IC_DATA, DC_DATA, L2_WDATA;
    logic          IC_DATA_VALID, DC_DATA_VALID, DC_WB_DONE, L2_REQ_VALID, L2_REQ_WRITE, OVERRUN;
    logic [AW-1:0] L2_REQ_ADDR;

    l2_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .IC_ADDR_VALID(IC_ADDR_VALID), .IC_ADDR(IC_ADDR), .IC_DATA(IC_DATA), .IC_DATA_VALID(IC_DATA_VALID),
        .DC_ADDR_VALID(DC_ADDR_VALID), .DC_ADDR(DC_ADDR), .DC_WB_VALID(DC_WB_VALID), .DC_WADDR(DC_WADDR),
        .DC_WDATA(DC_WDATA), .DC_DATA(DC_DATA), .DC_DATA_VALID(DC_DATA_VALID), .DC_WB_DONE(DC_WB_DONE),
        .L2_REQ_VALID(L2_REQ_VALID), .L2_REQ_READY(L2_REQ_READY), .L2_REQ_WRITE(L2_REQ_WRITE),
        .L2_REQ_ADDR(L2_REQ_ADDR), .L2_WDATA(L2_WDATA), .L2_RESP_VALID(L2_RESP_VALID),
        .L2_RDATA(L2_RDATA), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int hs_cnt = 0;
    logic [AW:0] ord_q[$];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", nm, act[63:0], exp[63:0]);
        end
    endtask

    // Reference model: slot i = 0 IC read, 1 DC read, 2 DC writeback; phase 0 idle, 1 offering, 2 awaiting reply
    bit            m_pend [3];
    logic [AW-1:0] m_addr [3];
    logic [LW-1:0] m_wd;
    int            m_ph, m_g;
    bit            m_favor_ic;
    logic [LW-1:0] e_icd, e_dcd, e_wdata;
    logic [AW-1:0] e_addr;
    bit            e_icv, e_dcv, e_wbd, e_write, e_ovr;

    always @(posedge CLK) begin : model
        bit            pl [3];
        logic [AW-1:0] pa [3];
        if (RST) begin
            for (int s = 0; s < 3; s++) begin m_pend[s] = 0; m_addr[s] = '0; end
            m_wd = '0; m_ph = 0; m_g = 0; m_favor_ic = 0;
            e_icd = '0; e_dcd = '0; e_wdata = '0; e_addr = '0;
            e_icv = 0; e_dcv = 0; e_wbd = 0; e_write = 0; e_ovr = 0;
        end else begin
            e_icv = 0; e_dcv = 0; e_wbd = 0;
            pl[0] = IC_ADDR_VALID; pl[1] = DC_ADDR_VALID; pl[2] = DC_WB_VALID;
            pa[0] = IC_ADDR;       pa[1] = DC_ADDR;       pa[2] = DC_WADDR;
            for (int s = 0; s < 3; s++) begin
                if (pl[s]) begin
                    if (m_pend[s]) e_ovr = 1;
                    else begin
                        m_pend[s] = 1; m_addr[s] = pa[s];
                        if (s == 2) m_wd = DC_WDATA;
                    end
                end
            end
            if (m_ph == 0) begin
                if (m_pend[0] || m_pend[1] || m_pend[2]) begin
                    if (m_pend[2]) m_g = 2;
                    else if (m_pend[0] && m_pend[1]) begin
`ifdef L2_ARB_RR_EN
                        m_g = m_favor_ic ? 0 : 1;
                        m_favor_ic = !m_favor_ic;
`else
                        m_g = 1;
`endif
                    end else m_g = m_pend[1] ? 1 : 0;
                    e_addr = m_addr[m_g];
                    e_write = (m_g == 2);
                    if (m_g == 2) e_wdata = m_wd;
                    m_ph = 1;
                end
            end else if (m_ph == 1) begin
                if (L2_REQ_READY) m_ph = 2;
            end else if (L2_RESP_VALID) begin
                m_ph = 0;
                m_pend[m_g] = 0;
                if (m_g == 0) begin e_icd = L2_RDATA; e_icv = 1; end
                else if (m_g == 1) begin e_dcd = L2_RDATA; e_dcv = 1; end
                else e_wbd = 1;
            end
        end
    end

    always @(posedge CLK)
        if (!RST && L2_REQ_VALID && L2_REQ_READY) hs_cnt++;

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_req_valid", LW'(L2_REQ_VALID), LW'(m_ph == 1));
            chk("m_req_write", LW'(L2_REQ_WRITE), LW'(e_write));
            chk("m_req_addr", LW'(L2_REQ_ADDR), LW'(e_addr));
            chk("m_wdata", L2_WDATA, e_wdata);
            chk("m_ic_valid", LW'(IC_DATA_VALID), LW'(e_icv));
            chk("m_dc_valid", LW'(DC_DATA_VALID), LW'(e_dcv));
            chk("m_wb_done", LW'(DC_WB_DONE), LW'(e_wbd));
            chk("m_ic_data", IC_DATA, e_icd);
            chk("m_dc_data", DC_DATA, e_dcd);
            chk("m_overrun", LW'(OVERRUN), LW'(e_ovr));
        end
    end

    // Drive one-cycle pulses; returns at the negedge after they were sampled.
    task automatic pulse(input bit ic, input logic [AW-1:0] ia, input bit dc, input logic [AW-1:0] da,
                         input bit wb, input logic [AW-1:0] wa, input logic [LW-1:0] wd);
        IC_ADDR_VALID = ic; IC_ADDR = ia;
        DC_ADDR_VALID = dc; DC_ADDR = da;
        DC_WB_VALID = wb; DC_WADDR = wa; DC_WDATA = wd;
        @(negedge CLK);
        IC_ADDR_VALID = 0; DC_ADDR_VALID = 0; DC_WB_VALID = 0;
    endtask

    // Acts as L2: wait for a request, stall READY, accept, then reply after resp_delay cycles.
    task automatic serve(input int rdy_delay, input int resp_delay, input logic [LW-1:0] rd);
        int n = 0;
        while (!L2_REQ_VALID && n < 30) begin @(negedge CLK); n++; end
        if (!L2_REQ_VALID) begin
            chk("req_timeout", LW'(L2_REQ_VALID), LW'(1));
            return;
        end
        repeat (rdy_delay) @(negedge CLK);
        ord_q.push_back({L2_REQ_WRITE, L2_REQ_ADDR});
        L2_REQ_READY = 1;
        @(negedge CLK);
        L2_REQ_READY = 0;
        repeat (resp_delay - 1) @(negedge CLK);
        L2_RDATA = rd; L2_RESP_VALID = 1;
        @(negedge CLK);
        L2_RESP_VALID = 0;
    endtask

    initial begin
        logic [LW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, pat_g, pat_h;
        logic [AW:0]   exp_ord [4];
        int            h0;
        pat_a = {16{64'hA5A5_0000_1111_0001}};
        pat_b = {16{64'hB0B0_2222_3333_0002}};
        pat_c = {16{64'hC3C3_4444_5555_0003}};
        pat_d = {16{64'hD00D_6666_7777_0004}};
        pat_e = {16{64'hE1E1_8888_9999_0005}};
        pat_f = {16{64'hF00F_AAAA_BBBB_0006}};
        pat_g = {16{64'h1234_CCCC_DDDD_0007}};
        pat_h = {16{64'h5678_EEEE_FFFF_0008}};

        repeat (3) @(negedge CLK);
        chk_en = 1;
        RST = 0;
        chk("rst_req_valid", LW'(L2_REQ_VALID), LW'(0));
        chk("rst_overrun", LW'(OVERRUN), LW'(0));
        chk("rst_ic_data", IC_DATA, '0);
        @(negedge CLK);

        // IC refill alone
        pulse(1, 25'h0000123, 0, '0, 0, '0, '0);
        chk("t1_valid_t1", LW'(L2_REQ_VALID), LW'(1));
        chk("t1_addr", LW'(L2_REQ_ADDR), LW'(25'h0000123));
        chk("t1_write", LW'(L2_REQ_WRITE), LW'(0));
        serve(0, 3, pat_a);
        chk("t1_ic_valid", LW'(IC_DATA_VALID), LW'(1));
        chk("t1_ic_data", IC_DATA, pat_a);
        chk("t1_dc_valid", LW'(DC_DATA_VALID), LW'(0));
        @(negedge CLK);
        chk("t1_ic_valid_drop", LW'(IC_DATA_VALID), LW'(0));
        chk("t1_ic_data_hold", IC_DATA, pat_a);

        // Writeback and DC read together: writeback goes first
        pulse(0, '0, 1, 25'h10, 1, 25'h10, pat_b);
        chk("t2_write", LW'(L2_REQ_WRITE), LW'(1));
        chk("t2_wdata", L2_WDATA, pat_b);
        serve(0, 2, pat_h);
        chk("t2_wb_done", LW'(DC_WB_DONE), LW'(1));
        chk("t2_dc_valid_early", LW'(DC_DATA_VALID), LW'(0));
        serve(0, 2, pat_c);
        chk("t2_dc_valid", LW'(DC_DATA_VALID), LW'(1));
        chk("t2_dc_data", DC_DATA, pat_c);
        chk("t2_order0", LW'(ord_q[ord_q.size()-2]), LW'({1'b1, 25'h10}));
        chk("t2_order1", LW'(ord_q[ord_q.size()-1]), LW'({1'b0, 25'h10}));

        // Two rounds of simultaneous IC and DC reads
        ord_q.delete();
        pulse(1, 25'h200, 1, 25'h300, 0, '0, '0);
        serve(0, 2, pat_d);
        serve(0, 2, pat_e);
        pulse(1, 25'h201, 1, 25'h301, 0, '0, '0);
        serve(0, 2, pat_f);
        serve(0, 2, pat_g);
`ifdef L2_ARB_RR_EN
        exp_ord[0] = {1'b0, 25'h300}; exp_ord[1] = {1'b0, 25'h200};
        exp_ord[2] = {1'b0, 25'h201}; exp_ord[3] = {1'b0, 25'h301};
`else
        exp_ord[0] = {1'b0, 25'h300}; exp_ord[1] = {1'b0, 25'h200};
        exp_ord[2] = {1'b0, 25'h301}; exp_ord[3] = {1'b0, 25'h201};
`endif
        chk("t3_count", LW'(ord_q.size()), LW'(4));
        for (int i = 0; i < 4 && i < ord_q.size(); i++)
            chk($sformatf("t3_order%0d", i), LW'(ord_q[i]), LW'(exp_ord[i]));

        // READY held low for 5 cycles
        h0 = hs_cnt;
        pulse(1, 25'h55, 0, '0, 0, '0, '0);
        serve(5, 2, pat_d);
        chk("t4_handshakes", LW'(hs_cnt - h0), LW'(1));
        chk("t4_ic_data", IC_DATA, pat_d);

        // Second IC pulse while IC pending
        h0 = hs_cnt;
        pulse(1, 25'h66, 0, '0, 0, '0, '0);
        pulse(1, 25'h77, 0, '0, 0, '0, '0);
        chk("t5_overrun", LW'(OVERRUN), LW'(1));
        serve(0, 2, pat_f);
        chk("t5_ic_data", IC_DATA, pat_f);
        repeat (5) @(negedge CLK);
        chk("t5_handshakes", LW'(hs_cnt - h0), LW'(1));
        chk("t5_addr", LW'(ord_q[ord_q.size()-1]), LW'({1'b0, 25'h66}));
        chk("t5_overrun_sticky", LW'(OVERRUN), LW'(1));

        // Reset while awaiting the reply, then a late reply
        pulse(1, 25'h88, 0, '0, 0, '0, '0);
        L2_REQ_READY = 1;
        @(negedge CLK);
        L2_REQ_READY = 0;
        RST = 1;
        @(negedge CLK);
        RST = 0;
        L2_RDATA = pat_e; L2_RESP_VALID = 1;
        @(negedge CLK);
        L2_RESP_VALID = 0;
        chk("t6_ic_valid", LW'(IC_DATA_VALID), LW'(0));
        chk("t6_dc_valid", LW'(DC_DATA_VALID), LW'(0));
        chk("t6_ic_data", IC_DATA, '0);
        chk("t6_overrun", LW'(OVERRUN), LW'(0));
        chk("t6_req_addr", LW'(L2_REQ_ADDR), LW'(0));
        repeat (3) @(negedge CLK);
        chk("t6_req_valid", LW'(L2_REQ_VALID), LW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
